// File: rtl/cla_pkg.sv
// Shared constants and group propagate/generate helper for the pipelined CLA adder.
package cla_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefGroup = 4;
  localparam int unsigned MaxGroup = 32;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Combined propagate/generate over the lowest n bit positions (n = 0 gives p=1, g=0).
  function automatic pg_t grp_pg(input logic [MaxGroup-1:0] p,
                                 input logic [MaxGroup-1:0] g,
                                 input int unsigned         n);
    pg_t r;
    r.p = 1'b1;
    r.g = 1'b0;
    for (int unsigned i = 0; i < MaxGroup; i++) begin
      if (i < n) begin
        r.g = g[i] | (p[i] & r.g);
        r.p = r.p & p[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Valid/ready operand and result streams of the pipelined CLA adder.
// The sub signal exists only when CLA_ADDSUB_EN is defined.
interface cla_pipe_adder_if import cla_pkg::*; #(
  parameter int unsigned WIDTH = DefWidth
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_ADDSUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin,
`ifdef CLA_ADDSUB_EN
    output sub,
`endif
    input  in_ready, out_valid, sum, cout,
    output out_ready
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef CLA_ADDSUB_EN
    input  sub,
`endif
    output in_ready, out_valid, sum, cout,
    input  out_ready
  );

endinterface

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block with group propagate/generate outputs.
module cla_group import cla_pkg::*; #(
  parameter int unsigned GROUP = DefGroup
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             P,
  output logic             G
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP-1:0] c;
  pg_t              lo;
  pg_t              pg;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    lo = '0;
    c  = '0;
    // Each bit carry is formed from ci and the lower-bit p/g terms directly.
    for (int unsigned i = 0; i < GROUP; i++) begin
      lo   = grp_pg(MaxGroup'(p), MaxGroup'(g), i);
      c[i] = lo.g | (lo.p & ci);
    end
    pg = grp_pg(MaxGroup'(p), MaxGroup'(g), GROUP);
    s  = p ^ c;
    co = pg.g | (pg.p & ci);
    P  = pg.p;
    G  = pg.g;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder: one GROUP-bit group per stage, carry registered between stages.
// Defining CLA_ADDSUB_EN adds the sub input (a - b computed as a + ~b + 1).
module cla_pipe_adder import cla_pkg::*; #(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned GROUP = DefGroup
) (
  input  logic           clk,
  input  logic           rst,
  cla_pipe_adder_if.slave bus
);

  localparam int unsigned NSTG = WIDTH / GROUP;

  logic             adv;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  logic [NSTG-1:0]  vld_q, vld_d, vld_st;
  logic [NSTG-1:0]  c_q, c_d, c_st;
  logic [NSTG-1:0]  grp_co, grp_p, grp_g;
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] a_d [NSTG];
  logic [WIDTH-1:0] a_st [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] b_d [NSTG];
  logic [WIDTH-1:0] b_st [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];
  logic [WIDTH-1:0] s_d [NSTG];
  logic [WIDTH-1:0] s_st [NSTG];
  logic [GROUP-1:0] grp_s [NSTG];

  // Single global stall: the whole pipe moves only when the output slot can drain.
  assign adv          = ~vld_q[NSTG-1] | bus.out_ready;
  assign bus.in_ready = adv;

`ifdef CLA_ADDSUB_EN
  // b is inverted at capture, so sub never travels down the pipe.
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub | bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  always_comb begin : stage_in
    vld_st[0] = bus.in_valid;
    a_st[0]   = bus.a;
    b_st[0]   = b_in;
    s_st[0]   = '0;
    c_st[0]   = c_in;
    for (int unsigned k = 1; k < NSTG; k++) begin
      vld_st[k] = vld_q[k-1];
      a_st[k]   = a_q[k-1];
      b_st[k]   = b_q[k-1];
      s_st[k]   = s_q[k-1];
      c_st[k]   = c_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    cla_group #(
      .GROUP(GROUP)
    ) u_grp (
      .a  (a_st[k][k*GROUP +: GROUP]),
      .b  (b_st[k][k*GROUP +: GROUP]),
      .ci (c_st[k]),
      .s  (grp_s[k]),
      .co (grp_co[k]),
      .P  (grp_p[k]),
      .G  (grp_g[k])
    );
  end

  always_comb begin : stage_next
    vld_d = vld_q;
    c_d   = c_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    if (adv) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        vld_d[k]                   = vld_st[k];
        a_d[k]                     = a_st[k];
        b_d[k]                     = b_st[k];
        s_d[k]                     = s_st[k];
        s_d[k][k*GROUP +: GROUP]   = grp_s[k];
        c_d[k]                     = grp_co[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      s_q   <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
    end
  end

  assign bus.out_valid = vld_q[NSTG-1];
  assign bus.sum       = s_q[NSTG-1];
  assign bus.cout      = c_q[NSTG-1];

  // Group P/G and the last stage's operand copies have no consumer.
  logic unused_pg;
  assign unused_pg = ^{grp_p, grp_g, a_q[NSTG-1], b_q[NSTG-1]};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed cases plus randomized scoreboard on 16- and 8-bit instances.
// Sub-mode cases are included when CLA_ADDSUB_EN is defined.
module tb_cla_pipe_adder;
  import cla_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s16 = 1'b0;
  logic s8  = 1'b0;

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(16)) bus ();
  cla_pipe_adder_if #(.WIDTH(8))  bus8 ();

`ifdef CLA_ADDSUB_EN
  assign bus.sub  = s16;
  assign bus8.sub = s8;
`endif

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  cla_pipe_adder #(.WIDTH(8),  .GROUP(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_push  = 0;
  logic [16:0] q16 [$];
  logic [8:0]  q8 [$];

  logic [15:0] ta [8] = '{16'h1234, 16'h8000, 16'h00FF, 16'hFFFF,
                          16'h0001, 16'hAAAA, 16'hAAAA, 16'h7FFF};
  logic [15:0] tbv [8] = '{16'h4321, 16'h8000, 16'h0F01, 16'h0000,
                           16'h0001, 16'h5555, 16'h5555, 16'h0001};
  logic        tc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [16:0] te [8] = '{17'h05555, 17'h10000, 17'h01000, 17'h10000,
                          17'h00003, 17'h0FFFF, 17'h10000, 17'h08000};

  // {cout, sum} of a w-bit add (or a - b when s), straight from the arithmetic definition.
  function automatic logic [32:0] model(input int unsigned w, input logic [31:0] a,
                                        input logic [31:0] b, input logic c, input logic s);
    logic [32:0] m;
    logic [32:0] bb;
    logic [32:0] r;
    m  = (33'd1 << w) - 33'd1;
    bb = s ? ((~{1'b0, b}) & m) : ({1'b0, b} & m);
    r  = ({1'b0, a} & m) + bb + {32'd0, s | c};
    return r & ((m << 1) | 33'd1);
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
  endtask

  // Called at a falling edge with inputs set; scores both streams and advances one cycle.
  task automatic tick();
    logic [32:0] r;
    logic [16:0] e16;
    logic [8:0]  e8;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      r = model(16, 32'(bus.a), 32'(bus.b), bus.cin, s16);
      q16.push_back(r[16:0]);
      n_push++;
    end
    if (bus8.in_valid && bus8.in_ready) begin
      r = model(8, 32'(bus8.a), 32'(bus8.b), bus8.cin, s8);
      q8.push_back(r[8:0]);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q16.size() == 0) chk("out16_unexpected", 33'(q16.size()), 33'd1);
      else begin
        e16 = q16.pop_front();
        chk("out16", 33'({bus.cout, bus.sum}), 33'(e16));
      end
    end
    if (bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) chk("out8_unexpected", 33'(q8.size()), 33'd1);
      else begin
        e8 = q8.pop_front();
        chk("out8", 33'({bus8.cout, bus8.sum}), 33'(e8));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated op: out_valid must rise after the 4th edge counting the transfer edge.
  task automatic lat_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [16:0] exp);
    drive(1'b1, a, b, c);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_early"}, 33'(bus.out_valid), 33'd0);
      tick();
    end
    chk({tag, "_valid"}, 33'(bus.out_valid), 33'd1);
    chk({tag, "_res"}, 33'({bus.cout, bus.sum}), 33'(exp));
    tick();
    chk({tag, "_after"}, 33'(bus.out_valid), 33'd0);
  endtask

  initial begin
    int          n;
    int          first;
    int          guard;
    logic [16:0] snap;

    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a         = 8'h0;
    bus8.b         = 8'h0;
    bus8.cin       = 1'b0;
    bus8.out_ready = 1'b1;

    // Reset held 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_out", 33'({bus.out_valid, bus.cout, bus.sum}), 33'd0);
    end
    rst = 1'b0;
    #1 chk("rst_in_ready", 33'(bus.in_ready), 33'd1);
    tick();
    chk("idle_valid0", 33'(bus.out_valid), 33'd0);
    tick();
    chk("idle_valid1", 33'(bus.out_valid), 33'd0);

    // Single op with wrap-around carry
    lat_op("single", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);

    // Back-to-back stream on consecutive cycles
    n     = 0;
    first = -1;
    for (int c = 0; c < 24; c++) begin
      if (bus.out_valid) begin
        if (first < 0) first = c;
        chk("b2b_slot", 33'(c - first), 33'(n));
        if (n < 8) chk("b2b_res", 33'({bus.cout, bus.sum}), 33'(te[n]));
        n++;
      end
      if (c < 8) drive(1'b1, ta[c], tbv[c], tc[c]);
      else drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    chk("b2b_count", 33'(n), 33'd8);

    // Backpressure: fill, stall 5 cycles, then push and pop together
    bus.out_ready = 1'b0;
    #1;
    guard = 0;
    while (bus.in_ready && guard < 20) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      tick();
      guard++;
    end
    chk("bp_fill", 33'(guard), 33'd4);
    chk("bp_full_valid", 33'(bus.out_valid), 33'd1);
    snap = {bus.cout, bus.sum};
    repeat (5) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      #1 chk("bp_in_ready", 33'(bus.in_ready), 33'd0);
      tick();
      chk("bp_stable", 33'({bus.out_valid, bus.cout, bus.sum}), 33'({1'b1, snap}));
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_push_pop_ready", 33'(bus.in_ready), 33'd1);
    repeat (3) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    guard = 0;
    while (q16.size() != 0 && guard < 30) begin
      tick();
      guard++;
    end
    chk("bp_drain", 33'(q16.size()), 33'd0);

    // Reset with ops in flight
    repeat (4) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    chk("inflight_valid", 33'(bus.out_valid), 33'd1);
    rst = 1'b1;
    #1 chk("rst_async", 33'({bus.out_valid, bus.cout, bus.sum}), 33'd0);
    q16.delete();
    q8.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      tick();
      chk("rst_flushed", 33'(bus.out_valid), 33'd0);
    end
    lat_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 17'h01000);

`ifdef CLA_ADDSUB_EN
    s16 = 1'b1;
    lat_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 17'h0FFFE);
    lat_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 17'h10002);
    s16 = 1'b0;
`endif

    // Random traffic on both widths
    n_push = 0;
    guard  = 0;
    while (n_push < 10000 && guard < 40000) begin
      drive(1'($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom), 1'($urandom));
      bus.out_ready  = 1'($urandom_range(0, 9) < 7);
      bus8.in_valid  = 1'($urandom_range(0, 9) < 7);
      bus8.a         = 8'($urandom);
      bus8.b         = 8'($urandom);
      bus8.cin       = 1'($urandom);
      bus8.out_ready = 1'($urandom_range(0, 9) < 7);
`ifdef CLA_ADDSUB_EN
      s16 = 1'($urandom);
      s8  = 1'($urandom);
`endif
      tick();
      guard++;
    end
    chk("rand_ops", 33'(n_push >= 10000), 33'd1);
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    guard = 0;
    while ((q16.size() != 0 || q8.size() != 0) && guard < 20) begin
      tick();
      guard++;
    end
    chk("rand_drain16", 33'(q16.size()), 33'd0);
    chk("rand_drain8", 33'(q8.size()), 33'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
